memory_access: RTL and testbench



---
 rtl/memory_access_pkg.sv | 7 +
 rtl/execute_memory_if.sv | 12 +
 rtl/memory_fetch_if.sv | 12 +
 rtl/memory_writeback_if.sv | 23 ++
 rtl/memory_access_data_mem.sv | 32 +++
 rtl/memory_access.sv | 64 ++++++
 tb/tb_memory_access.sv | 130 +++++++++++++
 7 files changed

// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - shared defaults for the memory-access stage
package memory_access_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int MEM_DEPTH_DEF  = 256;

endpackage : memory_access_pkg

// File: rtl/execute_memory_if.sv
// rtl/execute_memory_if.sv - execute-to-memory stage bundle
interface execute_memory_if
   import memory_access_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  zero;

   modport ex  (output alu_result, output zero);
   modport mem (input  alu_result, input  zero);
endinterface : execute_memory_if

// File: rtl/memory_fetch_if.sv
// rtl/memory_fetch_if.sv - memory-to-fetch next-PC bundle
interface memory_fetch_if
   import memory_access_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic [DATA_WIDTH-1:0] condpc;
   logic                  branch_taken;

   modport mem   (output condpc, output branch_taken);
   modport fetch (input  condpc, input  branch_taken);
endinterface : memory_fetch_if

// File: rtl/memory_writeback_if.sv
// rtl/memory_writeback_if.sv - memory-stage controls and results bundle
interface memory_writeback_if
   import memory_access_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic                  WE;
   logic                  RE;
   logic [DATA_WIDTH-1:0] REG_B;
   logic [DATA_WIDTH-1:0] npc;
   logic [DATA_WIDTH-1:0] read_data;
   logic [DATA_WIDTH-1:0] LMD;
   logic [DATA_WIDTH-1:0] condpc;

   modport mem (
      input  WE, input RE, input REG_B, input npc,
      output read_data, output LMD, output condpc
   );
   modport ctl (
      output WE, output RE, output REG_B, output npc,
      input  read_data, input LMD, input condpc
   );
endinterface : memory_writeback_if

// File: rtl/memory_access_data_mem.sv
// rtl/memory_access_data_mem.sv - word RAM: sync write, async read, sync clear
module data_mem
   import memory_access_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = MEM_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   output logic [DATA_WIDTH-1:0]    rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Clear wins over a concurrent store so reset always leaves the RAM all-zero
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Read port returns pre-write contents during a same-cycle store
   assign rdata = mem[addr];

endmodule : data_mem

// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory stage: data RAM, LMD register, next-PC mux
module memory_access
   import memory_access_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int MEM_DEPTH  = MEM_DEPTH_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   execute_memory_if.mem   e_m_if,
   memory_writeback_if.mem mem_if,
   memory_fetch_if.mem     fetch_if
);

   localparam int AW = $clog2(MEM_DEPTH);

   logic [DATA_WIDTH-1:0] addr;
   logic [AW-1:0]         word_idx;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] lmd_q;
   logic [DATA_WIDTH-1:0] condpc;
   logic                  unused_addr_bits;

   // Byte address to word index; upper bits alias, byte offset dropped
   assign addr             = e_m_if.alu_result;
   assign word_idx         = addr[AW+1:2];
   assign unused_addr_bits = ^{addr[DATA_WIDTH-1:AW+2], addr[1:0]};

   data_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MEM_DEPTH)
   ) u_data_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_if.WE),
      .addr  (word_idx),
      .wdata (mem_if.REG_B),
      .rdata (mem_rdata)
   );

   // Load memory data register captures the old word even during a store
   always_ff @(posedge clk) begin
      if (rst_n) begin
         lmd_q <= '0;
      end else if (mem_if.RE) begin
         lmd_q <= mem_rdata;
      end
   end

   // Next-PC select is purely combinational and not affected by reset
   always_comb begin
      condpc = mem_if.npc;
      if (e_m_if.zero) begin
         condpc = e_m_if.alu_result;
      end
   end

   assign mem_if.read_data      = mem_if.RE ? mem_rdata : '0;
   assign mem_if.LMD            = lmd_q;
   assign mem_if.condpc         = condpc;
   assign fetch_if.condpc       = condpc;
   assign fetch_if.branch_taken = e_m_if.zero;

endmodule : memory_access

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - scoreboard bench for memory_access
module tb_memory_access;

   logic clk;
   logic rst_n;

   execute_memory_if   em ();
   memory_writeback_if mw ();
   memory_fetch_if     mf ();

   memory_access #(
      .DATA_WIDTH (32),
      .MEM_DEPTH  (256)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .e_m_if   (em),
      .mem_if   (mw),
      .fetch_if (mf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks;
   int unsigned n_fails;

   logic [31:0] ref_mem [256];
   logic [31:0] ref_lmd;
   logic [31:0] rd_q [$];
   logic [31:0] lmd_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: predict, drive, compare combinational outputs,
   // then compare LMD just after the rising edge
   task automatic cycle(input string tag, input logic rst, input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic z, input logic [31:0] npc);
      logic [7:0]  idx;
      logic [31:0] got;
      idx = a[9:2];
      @(negedge clk);
      rst_n         = rst;
      mw.WE         = we;
      mw.RE         = re;
      mw.REG_B      = d;
      mw.npc        = npc;
      em.alu_result = a;
      em.zero       = z;
      rd_q.push_back(re ? ref_mem[idx] : 32'h0);
      if (rst) begin
         for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
         ref_lmd = 32'h0;
      end else begin
         if (re) ref_lmd = ref_mem[idx];
         if (we) ref_mem[idx] = d;
      end
      lmd_q.push_back(ref_lmd);
      #1;
      if (!rst) begin
         got = rd_q.pop_front();
         check({tag, ".read_data"}, mw.read_data, got);
      end else begin
         void'(rd_q.pop_front());
      end
      check({tag, ".condpc"}, mw.condpc, z ? a : npc);
      check({tag, ".fetch_condpc"}, mf.condpc, z ? a : npc);
      check({tag, ".branch_taken"}, {31'h0, mf.branch_taken}, {31'h0, z});
      @(posedge clk);
      #1;
      if (lmd_q.size() == 0) begin
         check({tag, ".lmd_queue_empty"}, 32'h1, 32'h0);
      end else begin
         got = lmd_q.pop_front();
         check({tag, ".LMD"}, mw.LMD, got);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'hx;
      ref_lmd = 32'hx;

      // reset, then first load sees zeros
      cycle("reset",      1, 0, 0, 32'h0,   32'h0,        0, 32'h0);
      cycle("rd_after_rst",0, 0, 1, 32'h4,  32'h0,        0, 32'h0);
      // store then load
      cycle("wr4",        0, 1, 0, 32'h4,   32'hABCD1234, 0, 32'h10);
      cycle("rd4",        0, 0, 1, 32'h4,   32'h0,        0, 32'h14);
      cycle("wr8",        0, 1, 0, 32'h8,   32'h87654321, 0, 32'h18);
      cycle("rd8",        0, 0, 1, 32'h8,   32'h0,        0, 32'h1C);
      cycle("rd4_again",  0, 0, 1, 32'h4,   32'h0,        0, 32'h20);
      // RE=0: read_data forced to zero, LMD holds
      cycle("idle",       0, 0, 0, 32'h8,   32'h0,        0, 32'h24);
      // next-PC mux
      cycle("br_taken",   0, 0, 0, 32'h100, 32'h0,        1, 32'h200);
      cycle("br_not",     0, 0, 0, 32'h100, 32'h0,        0, 32'h200);
      // simultaneous store and load returns old data
      cycle("wr_rd4",     0, 1, 1, 32'h4,   32'h11111111, 0, 32'h28);
      cycle("rd4_new",    0, 0, 1, 32'h4,   32'h0,        0, 32'h2C);
      // address aliasing and top word, byte offset ignored
      cycle("alias404",   0, 0, 1, 32'h404, 32'h0,        0, 32'h30);
      cycle("wr_top",     0, 1, 0, 32'h3FC, 32'hDEADBEEF, 1, 32'h34);
      cycle("rd_top_al",  0, 0, 1, 32'hBFF, 32'h0,        0, 32'h38);
      cycle("wr_rd_top",  0, 1, 1, 32'hFFFFFFFC, 32'h5A5A5A5A, 1, 32'h3C);
      cycle("rd_top2",    0, 0, 1, 32'h3FD, 32'h0,        0, 32'h40);
      // random traffic
      for (int k = 0; k < 40; k++) begin
         cycle("rand", 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               {22'($urandom), 8'($urandom_range(0, 7)), 2'($urandom)},
               $urandom, 1'($urandom_range(0, 1)), $urandom);
      end
      // reset overrides a concurrent store/load
      cycle("mid_rst",    1, 1, 1, 32'h4,   32'hCAFEF00D, 0, 32'h44);
      cycle("rd4_rst",    0, 0, 1, 32'h4,   32'h0,        0, 32'h48);
      cycle("rd8_rst",    0, 0, 1, 32'h8,   32'h0,        0, 32'h4C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_memory_access
